ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_rx_fifo.sv | 110 +++++++++++
 tb/tb_ps2_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises raw pins, deframes 11-bit frames
// and queues scan-code bytes in a small FIFO popped via ready/nextdata_n.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  logic [2:0]    clk_sync;
  // Data is only ever read at stage 2, so a third stage would be unobservable.
  logic [1:0]    dat_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] to_cnt;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [7:0]    mem [DEPTH];

  logic fall;
  logic sample;
  logic frame_done;
  logic frame_ok;
  logic push;
  logic pop;
  logic empty;
  logic full;
  logic wr_en;
  logic timeout_hit;

  assign fall        = !clk_sync[1] && clk_sync[2];
  assign sample      = dat_sync[1];
  assign frame_done  = fall && (bit_cnt == 4'd10);
  assign frame_ok    = !shreg[0] && (^shreg[9:1]) && sample;
  assign push        = frame_done && frame_ok;
  assign timeout_hit = !fall && (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT - 1));

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[PW-2:0] == rptr[PW-2:0]);
  assign ready = !empty;
  assign pop   = !nextdata_n && !empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign data  = empty ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];

  // Pin synchronisers, deframer and inter-bit timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      dat_sync  <= {dat_sync[0], ps2_data};
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        shreg  <= {sample, shreg[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt   <= 4'd0;
          frame_err <= !frame_ok;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (timeout_hit) begin
          bit_cnt   <= 4'd0;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[DEPTH_LOG2-1:0]] <= shreg[8:1];
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are driven on the pins, expected bytes
// go into a scoreboard queue and are compared as the consumer pops them.
module tb_ps2_rx_fifo;

  localparam int unsigned TMO  = 300;
  localparam int          HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  logic [7:0] model_q[$];
  logic       ovf_exp = 1'b0;

  ps2_rx_fifo #(.DEPTH_LOG2(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par_flip,
                                             input logic stop);
    return {stop, (~^b) ^ par_flip, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic v);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b1), 11);
    if (model_q.size() < 8) model_q.push_back(b);
    else ovf_exp = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    exp = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
    check({tag, "_data"}, 32'(data), 32'(exp));
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    ovf_exp = 1'b0;
  endtask

  initial begin
    logic [10:0] f;
    int fe0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;

    // 1: single frame 1C with stop-edge latency check
    fe0 = fe_cnt;
    f = make_frame(8'h1C, 1'b0, 1'b1);
    check("t1_parity_bit", 32'(f[9]), 32'd0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_ready_early", 32'(ready), 32'd0);
    @(negedge clk);
    check("t1_ready_edge", 32'(ready), 32'd1);
    check("t1_data_edge", 32'(data), 32'h1C);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    model_q.push_back(8'h1C);
    check("t1_frame_err", 32'(fe_cnt - fe0), 32'd0);
    pop_check("t1_pop");
    check("t1_empty", 32'(ready), 32'd0);

    // 2: two frames, single-cycle pops
    send_good(8'hF0);
    send_good(8'h1C);
    pop_check("t2_pop0");
    check("t2_ready_mid", 32'(ready), 32'd1);
    pop_check("t2_pop1");
    check("t2_ready_end", 32'(ready), 32'd0);

    // 3: overflow on ninth frame, drain in order
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check("t3_overflow", 32'(overflow), 32'(ovf_exp));
    for (int i = 0; i < 8; i++) pop_check("t3_drain");
    check("t3_ready_end", 32'(ready), 32'd0);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    check("t3_overflow_rst", 32'(overflow), 32'd0);

    // 4: parity error then stop error
    fe0 = fe_cnt;
    send_bits(make_frame(8'h1C, 1'b1, 1'b1), 11);
    send_bits(make_frame(8'h1C, 1'b0, 1'b0), 11);
    check("t4_frame_err", 32'(fe_cnt - fe0), 32'd2);
    check("t4_ready", 32'(ready), 32'd0);

    // 5: timeout after partial frame, then good frame
    fe0 = fe_cnt;
    send_bits(make_frame(8'h77, 1'b0, 1'b1), 5);
    repeat (TMO + 10) @(negedge clk);
    check("t5_timeout_err", 32'(fe_cnt - fe0), 32'd1);
    check("t5_ready_mid", 32'(ready), 32'd0);
    send_good(8'h5A);
    check("t5_frame_err_total", 32'(fe_cnt - fe0), 32'd1);
    pop_check("t5_pop");

    // 6: push into full FIFO with simultaneous pop is not overflow
    for (int i = 0; i < 8; i++) send_good(8'h30 + 8'(i));
    f = make_frame(8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    @(negedge clk);
    ps2_data = f[10];
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    void'(model_q.pop_front());
    model_q.push_back(8'hA5);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    check("t6_overflow", 32'(overflow), 32'd0);
    check("t6_model_count", 32'(model_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("t6_drain");
    check("t6_ready_end", 32'(ready), 32'd0);

    // 6b: reset mid-frame, then a clean frame
    send_good(8'h11);
    send_bits(make_frame(8'h99, 1'b0, 1'b1), 5);
    do_reset();
    check("t6_ready_rst", 32'(ready), 32'd0);
    fe0 = fe_cnt;
    send_good(8'h66);
    check("t6_frame_err", 32'(fe_cnt - fe0), 32'd0);
    pop_check("t6_pop66");
    check("t6_ready_final", 32'(ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
